// File: rtl/grf_mp_pkg.sv
// Shared CPU register-file definitions: default widths, the hardwired-zero
// register index and the packed-port slicing helper.
package grf_mp_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

  // LSB of port k inside a packed vector of ports that are w bits wide each.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register busy bits: a claim marks a register owned by a long-latency
// producer, and that producer's writeback with rel1 releases it.
module grf_scoreboard
  import grf_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim_en,
  input  logic [ADDR_W-1:0]    claim_addr,
  input  logic                 we1,
  input  logic                 rel1,
  input  logic [ADDR_W-1:0]    wa1,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // The claim is applied after the release so a new producer keeps ownership.
  always_comb begin
    busy_d = busy_q;
    if (we1 && rel1) busy_d[wa1] = 1'b0;
    if (claim_en) busy_d[claim_addr] = 1'b1;
    if (ZERO_REG) busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file: two prioritised write ports, NUM_RD
// combinational read ports with optional write bypass, and a busy scoreboard.
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rel1,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr0_ok, wr1_ok;

  assign wr0_ok = we0 && !(ZERO_REG && (wa0 == ZERO_ADDR));
  assign wr1_ok = we1 && !(ZERO_REG && (wa1 == ZERO_ADDR));

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wa0] = wd0;
    if (wr1_ok) mem_d[wa1] = wd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      if (ZERO_REG && (addr == ZERO_ADDR)) begin
        data = '0;
      end else if (BYPASS && we1 && (wa1 == addr)) begin
        data = wd1;
      end else if (BYPASS && we0 && (wa0 == addr)) begin
        data = wd0;
      end
    end

    assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = data;
    // Busy is registered state only; a same-cycle release is not forwarded.
    assign rd_busy[k] = busy_vec[addr];
  end

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .we1        (we1),
    .rel1       (rel1),
    .wa1        (wa1),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: default, BYPASS=0/ZERO_REG=0 and 4-port narrow instances.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        we0 = 1'b0, we1 = 1'b0, rel1 = 1'b0, claim_en = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, claim_addr = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] busy_vec_a, busy_vec_b;

  logic [15:0] c_rd_addr = '0;
  logic [63:0] c_rd_data;
  logic [3:0]  c_rd_busy;
  logic        c_we0 = 1'b0, c_we1 = 1'b0;
  logic [3:0]  c_wa0 = '0, c_wa1 = '0;
  logic [15:0] c_wd0 = '0, c_wd1 = '0;
  logic [15:0] c_busy_vec;

  always #5 clk = ~clk;

  grf_mp u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .rel1(rel1),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec_a)
  );

  grf_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .rel1(rel1),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec_b)
  );

  grf_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) u_dut_c (
    .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
    .rel1(1'b0), .claim_en(1'b0), .claim_addr(4'd0), .busy_vec(c_busy_vec)
  );

  typedef struct {
    string       nm;
    logic [63:0] v;
  } exp_t;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rel1;
    logic        cl;
    logic [4:0]  ca;
    logic [4:0]  ra0, ra1;
    logic [31:0] d0, d1;
    logic        b0, b1;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string nm, input logic [63:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] act);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_underflow: got %0h, nothing expected", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got %0h required %0h", e.nm, act, e.v);
      end
    end
  endtask

  function automatic vec_t mkv(
    input logic w0, input logic [4:0] a0, input logic [31:0] x0,
    input logic w1, input logic [4:0] a1, input logic [31:0] x1, input logic r1,
    input logic cl, input logic [4:0] ca, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = x0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = x1; v.rel1 = r1;
    v.cl = cl; v.ca = ca; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
    return v;
  endfunction

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rel1 = 1'b0; claim_en = 1'b0;
  endtask

  function automatic logic [15:0] cpat(input int a);
    if (a == 0) return 16'h0;
    if (a == 15) return 16'hBEEF;
    return 16'(a * 16'h0101) ^ 16'hA5A5;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset is held from time zero.
    rd_addr = {5'd31, 5'd5};
    #3;
    push("reset_a_data", 64'h0); chk(rd_data_a);
    push("reset_a_busy", 64'h0); chk(64'(rd_busy_a));
    push("reset_a_bvec", 64'h0); chk(64'(busy_vec_a));
    @(negedge clk) reset = 1'b1;

    // Mid-cycle reset clears storage and overrides pending write/claim.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678; rd_addr = {5'd5, 5'd5};
    @(negedge clk);
    idle();
    #1;
    push("pre_reset_r5_a", 64'h12345678); chk(64'(rd_data_a[31:0]));
    push("pre_reset_r5_b", 64'h12345678); chk(64'(rd_data_b[31:0]));
    claim_en = 1'b1; claim_addr = 5'd5; we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
    #1 reset = 1'b0;
    #1;
    push("mid_reset_r5", 64'h0); chk(64'(rd_data_a[31:0]));
    push("mid_reset_bvec", 64'h0); chk(64'(busy_vec_a));
    @(posedge clk);
    #1;
    idle();
    rd_addr = {5'd6, 5'd5};
    #1;
    push("reset_hold_r6", 64'h0); chk(64'(rd_data_b[63:32]));
    push("reset_hold_bvec", 64'h0); chk(64'(busy_vec_b));
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    #1;
    push("post_reset_r5", 64'h0); chk(64'(rd_data_b[31:0]));
    push("post_reset_r6", 64'h0); chk(64'(rd_data_b[63:32]));
    push("post_reset_bvec", 64'h0); chk(64'(busy_vec_a));

    // Table rows for the default instance (BYPASS=1, ZERO_REG=1).
    tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0, 0, 7, 3,
                  32'h5555FFFF, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 3, 32'h5555FFFF, 0, 0, 0);
    tbl[3]  = mkv(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3, 7,
                  32'hDEADBEEF, 32'h5555FFFF, 0, 0);
    tbl[4]  = mkv(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0);
    tbl[7]  = mkv(0, 0, 0, 1, 9, 32'h42, 1, 0, 0, 9, 9, 32'h42, 32'h42, 1, 1);
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 32'h42, 32'hDEADBEEF, 0, 0);
    tbl[9]  = mkv(0, 0, 0, 1, 9, 32'h77, 1, 1, 9, 9, 9, 32'h77, 32'h77, 0, 0);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 12, 32'h77, 0, 1, 0);
    tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 32'h77, 32'h77, 1, 1);
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h77, 0, 1, 0);
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 9, 0, 32'h77, 0, 1);
    tbl[14] = mkv(1, 12, 32'h1234, 0, 0, 0, 0, 0, 0, 12, 12, 32'h1234, 32'h1234, 1, 1);
    tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 9, 32'h1234, 32'h77, 1, 1);
    tbl[16] = mkv(0, 0, 0, 1, 12, 32'h99, 0, 0, 0, 12, 0, 32'h99, 0, 1, 0);
    tbl[17] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 32'h99, 0, 1, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1; rel1 = tbl[i].rel1;
      claim_en = tbl[i].cl; claim_addr = tbl[i].ca;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      push($sformatf("row%0d_d0", i), 64'(tbl[i].d0));
      push($sformatf("row%0d_d1", i), 64'(tbl[i].d1));
      push($sformatf("row%0d_b0", i), 64'(tbl[i].b0));
      push($sformatf("row%0d_b1", i), 64'(tbl[i].b1));
      #2;
      chk(64'(rd_data_a[31:0]));
      chk(64'(rd_data_a[63:32]));
      chk(64'(rd_busy_a[0]));
      chk(64'(rd_busy_a[1]));
    end

    // ZERO_REG=0 instance kept the r0 write and claim; default one did not.
    @(negedge clk);
    idle();
    rd_addr = {5'd9, 5'd0};
    #1;
    push("zero_r0_a", 64'h0); chk(64'(rd_data_a[31:0]));
    push("nozero_r0_b", 64'hFFFFFFFF); chk(64'(rd_data_b[31:0]));
    push("zero_busy0_a", 64'h0); chk(64'(rd_busy_a[0]));
    push("nozero_busy0_b", 64'h1); chk(64'(rd_busy_b[0]));
    push("bvec_a", 64'h1200); chk(64'(busy_vec_a));
    push("bvec_b", 64'h1201); chk(64'(busy_vec_b));

    // BYPASS=0 shows the old value during the write cycle, new value after.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFEF00D; rd_addr = {5'd0, 5'd3};
    #1;
    push("byp_same_a", 64'hCAFEF00D); chk(64'(rd_data_a[31:0]));
    push("nobyp_same_b", 64'hDEADBEEF); chk(64'(rd_data_b[31:0]));
    @(negedge clk);
    idle();
    #1;
    push("byp_next_a", 64'hCAFEF00D); chk(64'(rd_data_a[31:0]));
    push("nobyp_next_b", 64'hCAFEF00D); chk(64'(rd_data_b[31:0]));

    // Four-port narrow instance: fill, write r0 and r15, read distinct sets.
    for (int a = 0; a < 15; a++) begin
      @(negedge clk);
      c_we0 = 1'b1; c_wa0 = 4'(a);
      c_wd0 = (a == 0) ? 16'hFFFF : cpat(a);
    end
    @(negedge clk);
    c_we0 = 1'b0;
    c_we1 = 1'b1; c_wa1 = 4'd15; c_wd1 = 16'hBEEF;
    @(negedge clk);
    c_we1 = 1'b0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        int a;
        a = (g == 4) ? (15 - k * 5) : (k * 4 + g);
        c_rd_addr[k*4 +: 4] = 4'(a);
        push($sformatf("c_g%0d_p%0d_a%0d", g, k, a), 64'(cpat(a)));
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        chk(64'(c_rd_data[k*16 +: 16]));
      end
    end
    push("c_busy", 64'h0); chk(64'(c_rd_busy));
    push("c_bvec", 64'h0); chk(64'(c_busy_vec));

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
